disp_scan6: RTL and testbench
=============================

Name: disp_scan6

Overview:
Display-side reader for the clock's BCD counter chain. Takes the six BCD digits (HH:MM:SS) from the hour/minute/second counters and time-multiplexes them onto one common-anode 7-segment bank. Provides frame-coherent snapshotting, hour leading-zero blanking, dash display for invalid codes, and blinking of the field being set. Sits between the counter chain and the board's segment/digit pins.

Parameters:
SCAN_DIV, 50000, CLK cycles per digit slot (>=2)
BLINK_FRAMES, 64, full frames per blink half-period (>=1)

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
ENABLE  in  1  scan advance enable; low freezes scanning
HOUR10  in  4  hour tens BCD
HOUR1  in  4  hour ones BCD
MIN10  in  4  minute tens BCD
MIN1  in  4  minute ones BCD
SEC10  in  4  second tens BCD
SEC1  in  4  second ones BCD
SET_SEL  in  2  field being set: 00 none, 01 hours, 10 minutes, 11 seconds
LZB  in  1  1 = blank hour-tens digit when 0
SEG  out  7  segments, active low, bit0=a ... bit6=g
DP  out  1  decimal point, active low
DIG  out  6  digit select, active low one-hot, bit0 = HOUR10 (leftmost) ... bit5 = SEC1
FRAME_START  out  1  one-cycle pulse when digit 0 of a new frame is shown

Behaviour:
- Reset (sync, on CLK edge with RESET=1): SEG=7'h7F, DP=1, DIG=6'h3F, FRAME_START=0; prescaler=0; digit index=5; frame counter=0; blink phase=0; snapshot=0.
- Prescaler: counts 0..SCAN_DIV-1 while ENABLE=1, wraps to 0; tick = (prescaler==SCAN_DIV-1 && ENABLE).
- On tick edge: index advances 0->1->...->5->0. All outputs registered, updated on the same edge as the index (1 cycle after tick cycle).
- Initial index 5 => first tick after reset starts a frame at digit 0; outputs stay dark until then (SCAN_DIV cycles).
- Snapshot: on the 5->0 edge all six inputs are loaded into the snapshot; digit 0 on that edge decodes the freshly loaded value. All six digits of a frame come from one snapshot; input changes mid-frame are not shown until the next frame.
- FRAME_START=1 for exactly the cycle after the 5->0 edge; 0 otherwise.
- Decode: 0-9 standard patterns; codes 10-15 show dash (g only, SEG=7'h3F).
- Leading zero: slot 0 with LZB=1 and snapshot HOUR10==0 -> SEG=7'h7F; DIG still asserted.
- DP: 0 (lit) on slots 1 and 3 (HH.MM.SS separators), 1 elsewhere; never blinked or blanked.
- Blink: frame counter increments on each 5->0 edge, counts 0..BLINK_FRAMES-1; on wrap, blink phase toggles. Phase 1 and SET_SEL selects a field -> both slots of that field show SEG=7'h7F (DIG unchanged). Phase 0 or SET_SEL=00 -> normal. SET_SEL sampled live every slot.
- Blank priority: blink blank > leading-zero blank > decode.
- ENABLE=0: prescaler, index, frame counter, blink phase, all outputs hold. FRAME_START held pulse is not possible: FRAME_START forced 0 while ENABLE=0.
- RESET mid-frame: next edge returns everything to reset values regardless of ENABLE.
- Exactly one DIG bit low after the first tick; never two.

Decomposition:
- Package disp_pkg: segment constants SEG_OFF=7'h7F, SEG_DASH=7'h3F, digit patterns 0-9 (active low); SET_SEL encodings SEL_NONE/SEL_HOUR/SEL_MIN/SEL_SEC; slot index constants 0-5.
- One sub-module: seg7_dec (combinational 4-bit BCD -> active-low SEG, dash for 10-15), instantiated once on the selected digit.

Test Plan:
- SCAN_DIV=4, inputs 12:34:56, LZB=0: after reset, dark 4 cycles; next edge DIG=6'b111110, SEG=7'h79 ("1"), DP=1, FRAME_START=1 one cycle; 4 cycles later DIG=6'b111101, SEG=7'h24 ("2"), DP=0, FRAME_START=0.
- Change inputs to 23:59:59 while slot 2 is shown -> slots 2-5 still show 3,4,5,6; next frame slot 0 shows "2" (SEG=7'h24).
- HOUR10=0: LZB=1 -> slot 0 SEG=7'h7F, DIG=6'b111110; LZB=0 -> slot 0 SEG=7'h40.
- BLINK_FRAMES=2, SET_SEL=10: frames 0-1 minutes normal; frames 2-3 slots 2,3 SEG=7'h7F with DIG still low; hours/seconds unaffected; frames 4-5 normal.
- SEC1=4'hC -> slot 5 SEG=7'h3F.
- ENABLE=0 for 10 cycles mid-slot -> DIG/SEG constant, FRAME_START=0; resume continues same slot count. RESET asserted mid-frame -> next edge SEG=7'h7F, DIG=6'h3F, DP=1.

Source files
------------

// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : disp_pkg
// Description : Shared constants for the six-digit display scanner:
//               active-low segment patterns, field-select codes, slot indices.
// Revision    : 1.0 - initial release
// ============================================================================
package disp_pkg;

  typedef logic [3:0] bcd_t;

  // Active-low segment patterns, bit0 = a ... bit6 = g
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;

  // Field being set
  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_HOUR = 2'b01;
  localparam logic [1:0] SEL_MIN  = 2'b10;
  localparam logic [1:0] SEL_SEC  = 2'b11;

  // Scan slots, left to right
  localparam logic [2:0] SLOT_H10 = 3'd0;
  localparam logic [2:0] SLOT_H1  = 3'd1;
  localparam logic [2:0] SLOT_M10 = 3'd2;
  localparam logic [2:0] SLOT_M1  = 3'd3;
  localparam logic [2:0] SLOT_S10 = 3'd4;
  localparam logic [2:0] SLOT_S1  = 3'd5;

  // Field select code that owns a given slot
  function automatic logic [1:0] slot_field(input logic [2:0] slot);
    case (slot)
      SLOT_H10, SLOT_H1: slot_field = SEL_HOUR;
      SLOT_M10, SLOT_M1: slot_field = SEL_MIN;
      SLOT_S10, SLOT_S1: slot_field = SEL_SEC;
      default:           slot_field = SEL_NONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/disp_scan6_if.sv
`default_nettype none
// ============================================================================
// Module      : disp_scan6_if
// Description : Counter-chain digits and control in, segment/digit pins out.
// Revision    : 1.0 - initial release
// ============================================================================
interface disp_scan6_if;
  import disp_pkg::*;

  logic       ENABLE;
  bcd_t       HOUR10;
  bcd_t       HOUR1;
  bcd_t       MIN10;
  bcd_t       MIN1;
  bcd_t       SEC10;
  bcd_t       SEC1;
  logic [1:0] SET_SEL;
  logic       LZB;
  logic [6:0] SEG;
  logic       DP;
  logic [5:0] DIG;
  logic       FRAME_START;

  // Counter chain / board side
  modport master (
    output ENABLE, HOUR10, HOUR1, MIN10, MIN1, SEC10, SEC1, SET_SEL, LZB,
    input  SEG, DP, DIG, FRAME_START
  );

  // Scanner side
  modport slave (
    input  ENABLE, HOUR10, HOUR1, MIN10, MIN1, SEC10, SEC1, SET_SEL, LZB,
    output SEG, DP, DIG, FRAME_START
  );

endinterface
`default_nettype wire

// File: rtl/seg7_dec.sv
`default_nettype none
// ============================================================================
// Module      : seg7_dec
// Description : BCD to active-low 7-segment decoder; 10-15 show a dash.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_dec
  import disp_pkg::*;
(
  input  wire bcd_t       bcd_i,
  output logic [6:0]      seg_o
);

  // Pure lookup, non-BCD codes fall through to the dash
  always_comb begin
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/disp_scan6.sv
`default_nettype none
// ============================================================================
// Module      : disp_scan6
// Description : Six-digit multiplexed 7-segment scanner with frame-coherent
//               snapshot, hour leading-zero blanking and set-field blinking.
// Revision    : 1.0 - initial release
// ============================================================================
module disp_scan6
  import disp_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  wire         CLK,
  input  wire         RESET,
  disp_scan6_if.slave bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0]   presc_q;
  logic [2:0]      idx_q, idx_d;
  logic [FW-1:0]   frame_q;
  logic            phase_q;
  logic            blink_q;     // blink phase frozen for the frame on screen
  logic [5:0][3:0] snap_q, snap_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic [5:0]      dig_q, dig_d;
  logic            fs_q;

  logic            tick;
  logic            frame_edge;
  logic            blink_act;
  logic [6:0]      dec_seg;
  logic [5:0][3:0] live;

  assign live       = {bus.SEC1, bus.SEC10, bus.MIN1, bus.MIN10, bus.HOUR1, bus.HOUR10};
  assign tick       = bus.ENABLE && (presc_q == PRESC_MAX);
  assign frame_edge = tick && (idx_q == SLOT_S1);
  assign idx_d      = (idx_q == SLOT_S1) ? SLOT_H10 : idx_q + 3'd1;
  // Digit 0 of a new frame must see the value being captured on this edge
  assign snap_d     = frame_edge ? live : snap_q;
  // The phase register flips on the frame edge; the old value governs the new frame
  assign blink_act  = frame_edge ? phase_q : blink_q;

  seg7_dec u_dec (
    .bcd_i (snap_d[idx_d]),
    .seg_o (dec_seg)
  );

  // Next slot's segment/DP/digit pattern, blink blank over leading-zero blank
  always_comb begin
    seg_d = dec_seg;
    if (blink_act && (bus.SET_SEL != SEL_NONE) && (slot_field(idx_d) == bus.SET_SEL))
      seg_d = SEG_OFF;
    else if ((idx_d == SLOT_H10) && bus.LZB && (snap_d[SLOT_H10] == 4'd0))
      seg_d = SEG_OFF;
    dp_d  = !((idx_d == SLOT_H1) || (idx_d == SLOT_M1));
    dig_d = ~(6'd1 << idx_d);
  end

  // Slot prescaler, frozen while scanning is disabled
  always_ff @(posedge CLK) begin
    if (RESET)
      presc_q <= '0;
    else if (bus.ENABLE)
      presc_q <= (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
  end

  // Slot index, frame snapshot and blink timing
  always_ff @(posedge CLK) begin
    if (RESET) begin
      idx_q   <= SLOT_S1;
      snap_q  <= '0;
      frame_q <= '0;
      phase_q <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      if (tick)
        idx_q <= idx_d;
      if (frame_edge) begin
        snap_q  <= live;
        blink_q <= phase_q;
        frame_q <= (frame_q == FRAME_MAX) ? '0 : frame_q + FW'(1);
        if (frame_q == FRAME_MAX)
          phase_q <= ~phase_q;
      end
    end
  end

  // Registered pin drivers, updated together with the slot index
  always_ff @(posedge CLK) begin
    if (RESET) begin
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
      dig_q <= 6'h3F;
      fs_q  <= 1'b0;
    end else begin
      fs_q <= frame_edge;
      if (tick) begin
        seg_q <= seg_d;
        dp_q  <= dp_d;
        dig_q <= dig_d;
      end
    end
  end

  assign bus.SEG         = seg_q;
  assign bus.DP          = dp_q;
  assign bus.DIG         = dig_q;
  assign bus.FRAME_START = fs_q & bus.ENABLE;

endmodule
`default_nettype wire

// File: tb/tb_disp_scan6.sv
`default_nettype none
// ============================================================================
// Module      : tb_disp_scan6
// Description : Scoreboard bench for disp_scan6 with a frame/slot-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_scan6;

  localparam int SCAN_DIV = 4;
  localparam int BF       = 2;

  logic CLK = 1'b0;
  logic RESET;

  disp_scan6_if bus ();

  disp_scan6 #(.SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BF)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [5:0] dig;
    logic       fs;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [6:0] pattern(input logic [3:0] v);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    if (v > 4'd9) return 7'h3F;
    return tbl[v];
  endfunction

  // Reference model: count enabled cycles and ticks, derive frame and slot
  initial begin : model
    bit         started = 0;
    int         en_cycles = 0;
    int         ticks = 0;
    logic [3:0] snap [6];
    exp_t       cur;
    int         slot, frame;
    logic [3:0] live [6];
    forever begin
      @(posedge CLK);
      if (RESET) begin
        started   = 1;
        en_cycles = 0;
        ticks     = 0;
        for (int i = 0; i < 6; i++) snap[i] = 4'd0;
        cur = '{seg: 7'h7F, dp: 1'b1, dig: 6'h3F, fs: 1'b0};
      end else if (started) begin
        cur.fs = 1'b0;
        if (bus.ENABLE) begin
          if (en_cycles % SCAN_DIV == SCAN_DIV - 1) begin
            slot  = ticks % 6;
            frame = ticks / 6;
            ticks++;
            if (slot == 0) begin
              live = '{bus.HOUR10, bus.HOUR1, bus.MIN10, bus.MIN1, bus.SEC10, bus.SEC1};
              for (int i = 0; i < 6; i++) snap[i] = live[i];
            end
            if (((frame / BF) % 2 == 1) && bus.SET_SEL != 2'b00 && (slot / 2 + 1 == int'(bus.SET_SEL)))
              cur.seg = 7'h7F;
            else if (slot == 0 && bus.LZB && snap[0] == 4'd0)
              cur.seg = 7'h7F;
            else
              cur.seg = pattern(snap[slot]);
            cur.dp  = !(slot == 1 || slot == 3);
            cur.dig = 6'h3F;
            cur.dig[slot] = 1'b0;
            cur.fs  = (slot == 0);
          end
          en_cycles++;
        end
      end
      if (started) q.push_back(cur);
    end
  end

  // Monitor: pins are presented every cycle; compare against the oldest expectation
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({bus.SEG, bus.DP, bus.DIG, bus.FRAME_START} !== e) begin
          errors++;
          $display("FAIL scan t=%0t: got seg=%h dp=%b dig=%b fs=%b, want seg=%h dp=%b dig=%b fs=%b",
                   $time, bus.SEG, bus.DP, bus.DIG, bus.FRAME_START, e.seg, e.dp, e.dig, e.fs);
        end
      end
    end
  end

  task automatic set_time(input logic [3:0] h10, h1, m10, m1, s10, s1);
    bus.HOUR10 = h10; bus.HOUR1 = h1; bus.MIN10 = m10;
    bus.MIN1   = m1;  bus.SEC10 = s10; bus.SEC1 = s1;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Stimulus: directed scenarios followed by a randomized soak
  initial begin : stim
    RESET = 1'b1;
    bus.ENABLE = 1'b1; bus.SET_SEL = 2'b00; bus.LZB = 1'b0;
    set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    run(3);
    RESET = 1'b0;
    // first frame 12:34:56, then change inputs while slot 2 is on screen
    run(SCAN_DIV * 3 + 1);
    set_time(4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9);
    run(SCAN_DIV * 6 * 2);
    // hour leading-zero blanking on and off
    bus.HOUR10 = 4'd0; bus.LZB = 1'b1;
    run(SCAN_DIV * 6 * 2);
    bus.LZB = 1'b0;
    run(SCAN_DIV * 6 * 2);
    // minute field blinking across several blink periods
    bus.SET_SEL = 2'b10;
    run(SCAN_DIV * 6 * 6);
    bus.SET_SEL = 2'b00;
    // invalid code on seconds ones
    bus.SEC1 = 4'hC;
    run(SCAN_DIV * 6 * 2);
    // scan freeze mid-slot
    run(2);
    bus.ENABLE = 1'b0;
    run(10);
    bus.ENABLE = 1'b1;
    run(SCAN_DIV * 5);
    // reset mid-frame
    RESET = 1'b1;
    run(1);
    RESET = 1'b0;
    run(SCAN_DIV * 6 * 2);
    // randomized soak
    for (int c = 0; c < 4000; c++) begin
      @(negedge CLK);
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 5))
          0: bus.HOUR10 = 4'($urandom_range(0, 15));
          1: bus.HOUR1  = 4'($urandom_range(0, 15));
          2: bus.MIN10  = 4'($urandom_range(0, 15));
          3: bus.MIN1   = 4'($urandom_range(0, 15));
          4: bus.SEC10  = 4'($urandom_range(0, 15));
          default: bus.SEC1 = 4'($urandom_range(0, 15));
        endcase
      end
      if ($urandom_range(0, 9) == 0) bus.ENABLE = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) bus.SET_SEL = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) bus.LZB = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) bus.HOUR10 = 4'd0;
      RESET = ($urandom_range(0, 699) == 0);
    end
    @(negedge CLK);
    RESET = 1'b0;
    run(4);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
